// File: rtl/muller_c_array.sv
// Bank of clocked N-input Muller C-elements with input synchronisers, per-input
// polarity/enable masks, saturating transition counters and sticky stall flags.
module muller_c_array #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned INPUTS      = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned STALL_CYC   = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [CHANNELS*INPUTS-1:0]  in_data,
  input  logic [CHANNELS*INPUTS-1:0]  inv_mask,
  input  logic [CHANNELS*INPUTS-1:0]  en_mask,
  input  logic [CHANNELS-1:0]         cnt_clr,
  output logic [CHANNELS-1:0]         c_out,
  output logic [CHANNELS-1:0]         toggle,
  output logic [CHANNELS*CNT_W-1:0]   cnt,
  output logic [CHANNELS-1:0]         stall
);

  localparam int unsigned N    = CHANNELS * INPUTS;
  localparam int unsigned SC_W = $clog2(STALL_CYC + 1);

  logic [N-1:0]                       sync_q [SYNC_STAGES];
  logic [N-1:0]                       sync_d [SYNC_STAGES];
  logic [CHANNELS-1:0]                c_out_q, c_out_d;
  logic [CHANNELS-1:0]                toggle_q, toggle_d;
  logic [CHANNELS-1:0][CNT_W-1:0]     cnt_q, cnt_d;
  logic [CHANNELS-1:0]                stall_q, stall_d;
  logic [CHANNELS-1:0][SC_W-1:0]      scnt_q, scnt_d;
  logic [N-1:0]                       eff;
  logic [CHANNELS-1:0]                all1, all0;
  logic [INPUTS-1:0]                  en_c, ef_c;

  always_comb begin
    sync_d[0] = in_data;
    for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  always_comb begin
    c_out_d  = c_out_q;
    toggle_d = '0;
    cnt_d    = cnt_q;
    stall_d  = stall_q;
    scnt_d   = scnt_q;
    all1     = '0;
    all0     = '0;
    en_c     = '0;
    ef_c     = '0;
    eff      = sync_q[SYNC_STAGES-1] ^ inv_mask;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      en_c    = en_mask[c*INPUTS +: INPUTS];
      ef_c    = eff[c*INPUTS +: INPUTS] & en_c;
      all1[c] = (|en_c) && (ef_c == en_c);
      all0[c] = (|en_c) && (ef_c == '0);
      if (all1[c]) begin
        c_out_d[c] = 1'b1;
      end else if (all0[c]) begin
        c_out_d[c] = 1'b0;
      end
      toggle_d[c] = c_out_d[c] ^ c_out_q[c];
      // Clear wins over a same-cycle transition or disagree cycle.
      if (cnt_clr[c]) begin
        cnt_d[c]   = '0;
        scnt_d[c]  = '0;
        stall_d[c] = 1'b0;
      end else begin
        if (toggle_d[c] && (cnt_q[c] != '1)) begin
          cnt_d[c] = cnt_q[c] + CNT_W'(1);
        end
        if ((|en_c) && !all1[c] && !all0[c]) begin
          if (scnt_q[c] != SC_W'(STALL_CYC)) begin
            scnt_d[c] = scnt_q[c] + SC_W'(1);
          end
        end else begin
          scnt_d[c] = '0;
        end
        if (scnt_d[c] == SC_W'(STALL_CYC)) begin
          stall_d[c] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      c_out_q  <= '0;
      toggle_q <= '0;
      cnt_q    <= '0;
      stall_q  <= '0;
      scnt_q   <= '0;
    end else begin
      sync_q   <= sync_d;
      c_out_q  <= c_out_d;
      toggle_q <= toggle_d;
      cnt_q    <= cnt_d;
      stall_q  <= stall_d;
      scnt_q   <= scnt_d;
    end
  end

  assign c_out  = c_out_q;
  assign toggle = toggle_q;
  assign cnt    = cnt_q;
  assign stall  = stall_q;

endmodule
